ysyx_23060025_axi_rd_slave: RTL and testbench

- AXI-style read-channel responder: the memory side that answers the instruction-cache refill port.
- Accepts one AR request, waits a programmable latency, then returns an INCR burst of arlen+1 beats from an internal word-addressed SRAM model.
- Sits between the icache refill master and the backing store.
- Out-of-range or unsupported requests complete normally with an error response.

---
 rtl/ysyx_23060025_axi_rd_slave_pkg.sv | 19 +
 rtl/ysyx_23060025_axi_rd_slave_if.sv | 29 ++
 rtl/ysyx_23060025_axi_rd_slave_sram_sp.sv | 37 +++
 rtl/ysyx_23060025_axi_rd_slave.sv | 149 ++++++++++++++
 tb/tb_ysyx_23060025_axi_rd_slave.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060025_axi_rd_slave_pkg.sv
// Shared constants and types for the icache-refill read responder.
package ysyx_23060025_axi_rd_slave_pkg;

  localparam logic [1:0]  RRESP_OKAY        = 2'b00;
  localparam logic [1:0]  RRESP_SLVERR      = 2'b10;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DATA = 2'b10
  } state_e;

  // Byte stride between consecutive INCR beats.
  function automatic logic [31:0] beat_step(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/ysyx_23060025_axi_rd_slave_if.sv
// AR and R channel bundle between the icache refill master and the responder.
interface ysyx_23060025_axi_rd_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/ysyx_23060025_axi_rd_slave_sram_sp.sv
// Single-port word SRAM: synchronous registered read, byte-strobed write.
module ysyx_23060025_sram_sp #(
  parameter int MEM_AW = 10,
  parameter int DW     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              re,
  input  logic              rok,
  input  logic [MEM_AW-1:0] raddr,
  output logic [DW-1:0]     q,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [DW/8-1:0]   wstrb,
  input  logic [DW-1:0]     wdata
);

  logic [DW-1:0] mem [2**MEM_AW];

  // NOTE: the array has no reset; only the output register does, so the
  // storage maps onto a real SRAM macro instead of a flop bank.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // A same-edge write and read of one word returns the pre-write contents.
  // An errored beat loads zero so q can drive rdata directly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  q <= '0;
    else if (re) q <= rok ? mem[raddr] : '0;
  end

endmodule

// File: rtl/ysyx_23060025_axi_rd_slave.sv
// Read-channel responder: one AR, programmable latency, INCR burst from SRAM.
module ysyx_23060025_axi_rd_slave
  import ysyx_23060025_axi_rd_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEM_AW       = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int                    READ_LATENCY = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  ysyx_23060025_axi_rd_slave_if.slave axi,
  input  logic                    mem_wen,
  input  logic [ADDR_WIDTH-1:0]   mem_waddr,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_wdata
);

  localparam logic [ADDR_WIDTH:0] SPAN = {{ADDR_WIDTH{1'b0}}, 1'b1} << (MEM_AW + 2);
  localparam logic [15:0] LAT_LAST =
    (READ_LATENCY > 0) ? 16'(READ_LATENCY - 1) : 16'd0;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q, beat_q;
  logic [2:0]              size_q;
  logic [15:0]             lat_q;
  logic                    arready_q, rvalid_q, rlast_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    ar_hs, r_hs;
  logic                    load;
  logic [ADDR_WIDTH-1:0]   ld_addr, ld_off, w_off;
  logic [7:0]              ld_len, ld_beat;
  logic [2:0]              ld_size;
  logic                    ld_ok, w_ok;

  assign ar_hs = axi.arvalid && arready_q;
  assign r_hs  = rvalid_q && axi.rready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ar_hs) state_d = (READ_LATENCY > 0) ? S_WAIT : S_DATA;
      S_WAIT:  if (lat_q == LAT_LAST) state_d = S_DATA;
      S_DATA:  if (r_hs && rlast_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every output of a combinational block gets a default up front so
  // no path through the case leaves a value held, which would infer a latch.
  always_comb begin
    load    = 1'b0;
    ld_addr = addr_q;
    ld_len  = len_q;
    ld_size = size_q;
    ld_beat = beat_q;
    unique case (state_q)
      S_IDLE: if (ar_hs && READ_LATENCY == 0) begin
        load    = 1'b1;
        ld_addr = axi.araddr;
        ld_len  = axi.arlen;
        ld_size = axi.arsize;
        ld_beat = 8'd0;
      end
      S_WAIT: if (lat_q == LAT_LAST) begin
        load    = 1'b1;
        ld_beat = 8'd0;
      end
      S_DATA: if (r_hs && !rlast_q) begin
        load    = 1'b1;
        ld_addr = addr_q + ADDR_WIDTH'(beat_step(size_q));
        ld_beat = beat_q + 8'd1;
      end
      default: ;
    endcase
  end

  // Each beat is range-checked on its own address, so bursts may run off the end.
  assign ld_off = ld_addr - BASE_ADDR;
  assign ld_ok  = (ld_addr >= BASE_ADDR) && ({1'b0, ld_off} < SPAN) && (ld_size <= 3'd2);
  assign w_off  = mem_waddr - BASE_ADDR;
  assign w_ok   = (mem_waddr >= BASE_ADDR) && ({1'b0, w_off} < SPAN);

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RRESP_OKAY;
      rlast_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
    end else begin
      arready_q <= (state_d == S_IDLE);
      if (ar_hs) begin
        addr_q <= axi.araddr;
        len_q  <= axi.arlen;
        size_q <= axi.arsize;
      end
      if (state_q == S_WAIT) lat_q <= (lat_q == LAT_LAST) ? 16'd0 : lat_q + 16'd1;
      if (load) begin
        addr_q   <= ld_addr;
        beat_q   <= ld_beat;
        rresp_q  <= ld_ok ? RRESP_OKAY : RRESP_SLVERR;
        rlast_q  <= (ld_beat == ld_len);
        rvalid_q <= 1'b1;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  ysyx_23060025_sram_sp #(
    .MEM_AW (MEM_AW),
    .DW     (DATA_WIDTH)
  ) u_sram (
    .clock (clock),
    .reset (reset),
    .re    (load),
    .rok   (ld_ok),
    .raddr (ld_off[MEM_AW+1:2]),
    .q     (rdata_q),
    .we    (mem_wen && w_ok),
    .waddr (w_off[MEM_AW+1:2]),
    .wstrb (mem_wstrb),
    .wdata (mem_wdata)
  );

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;

endmodule

// File: tb/tb_ysyx_23060025_axi_rd_slave.sv
// Randomized bench for the read responder against a word-array reference model.
module tb_ysyx_23060025_axi_rd_slave;

  localparam int          MEM_AW = 6;
  localparam int          DEPTH  = 1 << MEM_AW;
  localparam int          LAT    = 2;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;

  ysyx_23060025_axi_rd_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  ysyx_23060025_axi_rd_slave #(
    .MEM_AW       (MEM_AW),
    .READ_LATENCY (LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .axi       (axi),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem_m [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
  endfunction

  function automatic void model_beat(input logic [31:0] a, input logic [2:0] sz,
                                     output logic [31:0] d, output logic [1:0] r);
    if (sz > 3'd2 || !model_in_range(a)) begin
      d = 32'h0;
      r = 2'b10;
    end else begin
      d = mem_m[(a - BASE) / 4];
      r = 2'b00;
    end
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [3:0] s,
                                      input logic [31:0] d);
    if (model_in_range(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mem_m[(a - BASE) / 4][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  task automatic bd_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    @(negedge clock);
    mem_wen = 1'b1; mem_waddr = a; mem_wstrb = s; mem_wdata = d;
    @(negedge clock);
    mem_wen = 1'b0;
    model_write(a, s, d);
  endtask

  task automatic midburst_reset();
    int stray;
    reset = 1'b0;
    #1;
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_arready", axi.arready, 0);
    check("rst_rdata_rlast", {axi.rlast, axi.rresp, axi.rdata}, 0);
    axi.rready = 1'b0; axi.arvalid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rel_arready", axi.arready, 1);
    stray = 0;
    repeat (12) begin
      @(negedge clock);
      if (axi.rvalid) stray++;
    end
    check("no_stray_beats", stray, 0);
  endtask

  // mode: 0 = rready always high, 1 = pattern 1,0,0,1, 2 = random.
  task automatic do_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input int mode, input bit collide, input int rst_beat, input bit junk);
    logic [34:0] exp_q[$];
    logic [31:0] d;
    logic [1:0]  r;
    logic        rdy;
    int          n, i, pc, guard;
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    for (int k = 0; k <= int'(len); k++) begin
      model_beat(a + 32'(k * (1 << sz)), sz, d, r);
      exp_q.push_back({(k == int'(len)), r, d});
    end

    @(negedge clock);
    axi.arvalid = 1'b1; axi.araddr = a; axi.arlen = len; axi.arsize = sz;
    n = 0;
    while (axi.arready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (axi.arready !== 1'b1) begin
      check("ar_timeout", axi.arready, 1);
      axi.arvalid = 1'b0;
      return;
    end
    @(negedge clock);
    axi.arvalid = junk;
    if (junk) axi.araddr = $urandom;
    check("arready_busy", axi.arready, 0);

    n = 1;
    while (!axi.rvalid && n < 40) begin
      if (collide && n == LAT) begin
        mem_wen = 1'b1; mem_waddr = a; mem_wstrb = 4'hf; mem_wdata = 32'h1111_1111;
      end
      @(negedge clock);
      n++;
      if (mem_wen) begin
        mem_wen = 1'b0;
        model_write(mem_waddr, mem_wstrb, mem_wdata);
      end
    end
    check("latency", n, LAT + 1);
    if (!axi.rvalid) begin
      axi.arvalid = 1'b0;
      return;
    end

    i = 0; pc = 0; guard = 0;
    while (i <= int'(len)) begin
      if (guard++ > 3000) begin
        check("r_timeout", i, int'(len) + 1);
        break;
      end
      if (axi.rvalid) begin
        check($sformatf("beat%0d@%h", i, a), {axi.rlast, axi.rresp, axi.rdata}, exp_q[i]);
        if (i == rst_beat) begin
          midburst_reset();
          return;
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = pat[pc % 4];
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        pc++;
        axi.rready = rdy;
        if (rdy && i == int'(len)) axi.arvalid = 1'b0;
        if (rdy) i++;
      end else begin
        if (mode == 0) check("throughput", axi.rvalid, 1);
        axi.rready = 1'b0;
      end
      if (junk && axi.arvalid) axi.araddr = $urandom;
      @(negedge clock);
    end
    axi.rready = 1'b0; axi.arvalid = 1'b0;
    check("done_rvalid", axi.rvalid, 0);
    check("done_arready", axi.arready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    axi.arvalid = 1'b0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.rready = 1'b0;
    mem_wen = 1'b0; mem_waddr = '0; mem_wstrb = '0; mem_wdata = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_arready", axi.arready, 0);
    check("reset_rvalid", axi.rvalid, 0);
    check("reset_beat", {axi.rlast, axi.rresp, axi.rdata}, 0);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_arready", axi.arready, 1);

    for (int w = 0; w < DEPTH; w++) bd_write(BASE + 32'(4 * w), 4'hf, $urandom);

    bd_write(BASE, 4'hf, 32'hDEAD_BEEF);
    do_burst(BASE, 8'd0, 3'd2, 0, 1'b0, -1, 1'b0);

    for (int w = 0; w < 4; w++) bd_write(BASE + 32'h10 + 32'(4 * w), 4'hf, 32'(w + 1));
    do_burst(BASE + 32'h10, 8'd3, 3'd2, 1, 1'b0, -1, 1'b0);

    do_burst(32'h7FFF_FFFC, 8'd1, 3'd2, 0, 1'b0, -1, 1'b0);
    do_burst(BASE, 8'd1, 3'd3, 0, 1'b0, -1, 1'b0);

    do_burst(BASE + 32'h20, 8'd0, 3'd2, 0, 1'b1, -1, 1'b0);
    do_burst(BASE + 32'h20, 8'd0, 3'd2, 0, 1'b0, -1, 1'b0);

    bd_write(BASE + 32'h24, 4'b0101, 32'hAABB_CCDD);
    do_burst(BASE + 32'h24, 8'd0, 3'd2, 0, 1'b0, -1, 1'b0);

    bd_write(BASE + 32'(4 * DEPTH), 4'hf, 32'hBAD0_BAD0);
    do_burst(BASE + 32'(4 * DEPTH) - 32'd4, 8'd1, 3'd2, 2, 1'b0, -1, 1'b0);
    do_burst(BASE, 8'd0, 3'd2, 0, 1'b0, -1, 1'b0);

    do_burst(32'hFFFF_FFFC, 8'd1, 3'd2, 0, 1'b0, -1, 1'b0);
    do_burst(BASE + 32'h1, 8'd7, 3'd0, 2, 1'b0, -1, 1'b1);
    do_burst(BASE + 32'h2, 8'd5, 3'd1, 1, 1'b0, -1, 1'b0);
    do_burst(BASE + 32'(4 * (DEPTH - 8)), 8'd255, 3'd2, 0, 1'b0, -1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 2) == 0)
        bd_write(BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 4'($urandom), $urandom);
      ra = BASE - 32'd32 + (32'($urandom_range(0, 4 * DEPTH + 64)) & 32'hFFFF_FFFC);
      do_burst(ra, 8'($urandom_range(0, 15)),
               ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
               2, 1'b0, -1, 1'($urandom_range(0, 1)));
    end

    do_burst(BASE, 8'd7, 3'd2, 0, 1'b0, 2, 1'b0);
    do_burst(BASE + 32'h8, 8'd2, 3'd2, 2, 1'b0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
